// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the CLA share arbiter: FSM states, datapath width
// and the signed-overflow rule used on the adder result.
package cla_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    // Overflow looks at the effective B operand, so subtraction is covered as well.
    function automatic logic calc_of(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b_eff,
                                     input logic [DATA_W-1:0] sum);
        return (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group generate/propagate
// feeding a second-level carry chain across the eight groups.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;
    logic        c;

    assign p = a ^ b;
    assign g = a & b;

    // Group carries are resolved from group G/P only, never from bit-level carries.
    always_comb begin
        gc = '0;
        c  = cin;
        for (int k = 0; k < 8; k++) begin
            gc[k] = c;
            c     = gg[k] | (gp[k] & c);
        end
        gc[8] = c;
    end

    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        logic [3:0] cl;

        assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k] = &p[B+3:B];

        assign cl[0] = gc[k];
        assign cl[1] = g[B] | (p[B] & gc[k]);
        assign cl[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign cl[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                     | (p[B+2] & p[B+1] & p[B] & gc[k]);

        assign sum[B+3:B] = p[B+3:B] ^ cl;
    end

    assign cout = gc[8];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches last+1, last+2, ... (mod NREQ) and
// returns a one-hot grant plus its encoded index. The pointer lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/cla_share_arbiter.sv
// Round-robin sequencer sharing one CLA_32bit among NREQ requesters; results return
// tagged with requester ID. Define CLA_ARB_SUB_EN to add the per-requester req_sub port.
module cla_share_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
`ifdef CLA_ARB_SUB_EN
    input  logic [NREQ-1:0]        req_sub,
`endif
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_of
);

    arb_state_e        state;
    logic [ID_W-1:0]   last;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gidx;
    logic              accept_ok;
    logic              handshake;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              cin_sel;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cin_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .valid (req_valid),
        .last  (last),
        .grant (grant),
        .idx   (gidx)
    );

    // A new request may be taken while idle, or while the held result is being consumed.
    assign accept_ok = (state == IDLE) || ((state == HOLD) && rsp_ready);
    assign req_ready = (accept_ok && !rst) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    assign a_sel = req_a[int'(gidx)*DATA_W +: DATA_W];

    // B and carry-in are folded into their effective form before latching.
    always_comb begin
        b_sel   = req_b[int'(gidx)*DATA_W +: DATA_W];
        cin_sel = req_cin[gidx];
`ifdef CLA_ARB_SUB_EN
        if (req_sub[gidx]) begin
            b_sel   = ~req_b[int'(gidx)*DATA_W +: DATA_W];
            cin_sel = 1'b1;
        end
`endif
    end

    CLA_32bit u_cla (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(NREQ - 1);
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_of    <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_of    <= calc_of(a_q, b_q, add_sum);
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                default: begin
                    if (state == HOLD && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (handshake) begin
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        cin_q <= cin_sel;
                        id_q  <= gidx;
                        last  <= gidx;
                        state <= CALC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Randomized + directed bench for cla_share_arbiter against a cycle-level reference
// model built from the arbitration and arithmetic rules (CLA_ARB_SUB_EN aware).
module tb_cla_share_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
`ifdef CLA_ARB_SUB_EN
    logic [NREQ-1:0]      req_sub;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 rsp_of;

    always #5 clk = ~clk;

    cla_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef CLA_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_of    (rsp_of)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Operands offered by each requester.
    logic [31:0]     op_a [NREQ];
    logic [31:0]     op_b [NREQ];
    logic [NREQ-1:0] op_cin;
    logic [NREQ-1:0] op_sub;

    // Reference model: phase 0 = free, 1 = computing, 2 = result on offer.
    int          m_ph;
    int          m_last;
    logic        m_valid;
    int          m_id;
    logic [31:0] m_sum;
    logic        m_cout, m_of;
    int          p_id;
    logic [31:0] p_sum;
    logic        p_cout, p_of;

    // Observed outputs of the last step.
    logic [NREQ-1:0] o_ready;
    logic            o_valid;
    logic [ID_W-1:0] o_id;
    logic [31:0]     o_sum;
    logic            o_cout, o_of;

    int dut_grants[$];
    int dut_rsp_ids[$];

    task automatic model_reset();
        m_ph = 0; m_last = NREQ - 1; m_valid = 1'b0;
        m_id = 0; m_sum = '0; m_cout = 1'b0; m_of = 1'b0;
    endtask

    // Result from plain integer arithmetic: a + b + cin, or a - b when subtracting.
    task automatic model_result(input int g);
        longint unsigned uf;
        longint          sf;
        longint          sa, sb;
        logic   [31:0]   be;
        int              c;
        be = op_b[g];
        c  = int'(op_cin[g]);
`ifdef CLA_ARB_SUB_EN
        if (op_sub[g]) begin
            be = ~op_b[g];
            c  = 1;
        end
`endif
        uf = longint'(op_a[g]) + longint'(be) + longint'(c);
        sa = longint'($signed(op_a[g]));
        sb = longint'($signed(be));
        sf = sa + sb + longint'(c);
        p_id   = g;
        p_sum  = uf[31:0];
        p_cout = uf[32];
        p_of   = (sf > 64'sd2147483647) || (sf < -64'sd2147483648);
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        logic            accept;
        int              g, j;
        logic [NREQ-1:0] er;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
        req_cin = op_cin;
`ifdef CLA_ARB_SUB_EN
        req_sub = op_sub;
`endif
        #1;
        o_ready = req_ready; o_valid = rsp_valid; o_id = rsp_id;
        o_sum = rsp_sum; o_cout = rsp_cout; o_of = rsp_of;

        accept = (m_ph == 0) || (m_ph == 2 && rr);
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        er = '0;
        if (accept && g >= 0) er[g] = 1'b1;

        chk("req_ready", o_ready, er);
        chk("rsp_valid", o_valid, m_valid);
        chk("rsp_id",    o_id,    m_id);
        chk("rsp_sum",   o_sum,   m_sum);
        chk("rsp_cout",  o_cout,  m_cout);
        chk("rsp_of",    o_of,    m_of);

        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
        if (rsp_valid && rr) dut_rsp_ids.push_back(int'(rsp_id));

        if (m_ph == 1) begin
            m_valid = 1'b1; m_id = p_id; m_sum = p_sum; m_cout = p_cout; m_of = p_of;
            m_ph = 2;
        end else begin
            if (m_ph == 2 && rr) begin
                m_valid = 1'b0;
                m_ph = 0;
            end
            if (accept && g >= 0) begin
                model_result(g);
                m_last = g;
                m_ph = 1;
            end
        end
    endtask

    task automatic do_reset(input logic [NREQ-1:0] v);
        @(negedge clk);
        rst = 1'b1;
        req_valid = v;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id",    rsp_id,    '0);
        chk("rst_rsp_sum",   rsp_sum,   '0);
        chk("rst_rsp_cout",  rsp_cout,  1'b0);
        chk("rst_rsp_of",    rsp_of,    1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        op_cin = '0;
        op_sub = '0;
    endtask

    logic [31:0] held_sum;
    logic [ID_W-1:0] held_id;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
`ifdef CLA_ARB_SUB_EN
        req_sub = '0;
`endif
        clear_ops();
        model_reset();
        do_reset('0);

        // Single request: 5 + 3 from requester 0, two cycles grant-to-valid.
        op_a[0] = 32'h5; op_b[0] = 32'h3;
        step(4'b0001, 1'b1);
        chk("t1_grant", o_ready, 4'b0001);
        step(4'b0000, 1'b1);
        chk("t1_calc_novalid", o_valid, 1'b0);
        step(4'b0000, 1'b1);
        chk("t1_valid", o_valid, 1'b1);
        chk("t1_sum", o_sum, 32'h8);
        chk("t1_id", o_id, 2'd0);
        chk("t1_cout_of", {o_cout, o_of}, 2'b00);

        // Signed overflow, then unsigned carry-out.
        op_a[1] = 32'h7FFF_FFFF; op_b[1] = 32'h1;
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("ovf_sum", o_sum, 32'h8000_0000);
        chk("ovf_cout_of", {o_cout, o_of}, 2'b01);
        op_a[3] = 32'hFFFF_FFFF; op_b[3] = 32'h1;
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("cry_sum", o_sum, 32'h0);
        chk("cry_cout_of", {o_cout, o_of}, 2'b10);
        chk("cry_id", o_id, 2'd3);

        // Fairness: everyone valid from reset gives 0,1,2,3,0,...
        do_reset('0);
        dut_grants.delete();
        dut_rsp_ids.delete();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom;
        end
        repeat (16) step(4'b1111, 1'b1);
        chk("fair_ngrant", dut_grants.size(), 8);
        chk("fair_nrsp", dut_rsp_ids.size(), 7);
        for (int i = 0; i < dut_grants.size(); i++) chk("fair_grant", dut_grants[i], i % NREQ);
        for (int i = 0; i < dut_rsp_ids.size(); i++) chk("fair_rspid", dut_rsp_ids[i], i % NREQ);

        // Backpressure: result held stable, no grants, then req2 granted on release.
        step(4'b0100, 1'b0);
        held_sum = o_sum;
        held_id  = o_id;
        chk("bp_valid", o_valid, 1'b1);
        repeat (5) begin
            step(4'b0100, 1'b0);
            chk("bp_ready", o_ready, 4'b0000);
            chk("bp_sum_stable", o_sum, held_sum);
            chk("bp_id_stable", o_id, held_id);
        end
        step(4'b0100, 1'b1);
        chk("bp_release_grant", o_ready, 4'b0100);
        repeat (3) step(4'b0000, 1'b1);

`ifdef CLA_ARB_SUB_EN
        // Subtraction: carry-in ignored, cout means no borrow.
        do_reset('0);
        clear_ops();
        op_sub[0] = 1'b1; op_a[0] = 32'h10; op_b[0] = 32'h20;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("sub_sum", o_sum, 32'hFFFF_FFF0);
        chk("sub_cout_of", {o_cout, o_of}, 2'b00);
        op_sub[1] = 1'b1; op_a[1] = 32'h8000_0000; op_b[1] = 32'h1; op_cin[1] = 1'b0;
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("sub_ovf_sum", o_sum, 32'h7FFF_FFFF);
        chk("sub_ovf_of", o_of, 1'b1);
`endif

        // Reset while computing: request dropped, no response afterwards.
        do_reset('0);
        clear_ops();
        op_a[0] = 32'h1234; op_b[0] = 32'h1;
        step(4'b0001, 1'b1);
        chk("rstcalc_grant", o_ready, 4'b0001);
        do_reset(4'b1111);
        repeat (4) begin
            step(4'b0000, 1'b1);
            chk("rstcalc_novalid", o_valid, 1'b0);
        end

        // Random traffic with occasional corner operands.
        do_reset('0);
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0] v;
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 7))
                    0: op_a[i] = 32'h7FFF_FFFF;
                    1: op_a[i] = 32'h8000_0000;
                    2: op_a[i] = 32'hFFFF_FFFF;
                    default: op_a[i] = $urandom;
                endcase
                op_b[i] = ($urandom_range(0, 5) == 0) ? 32'h1 : $urandom;
                v[i] = ($urandom_range(0, 9) < 4);
            end
            op_cin = NREQ'($urandom);
            op_sub = NREQ'($urandom);
            step(v, $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
